mips_mem_responder: RTL and testbench



---
 rtl/mips_mem_responder.sv | 139 +++++++++++++
 tb/tb_mips_mem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - variable-latency word memory responder for the multi-cycle MIPS memory port
module mips_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              Busy,
    output logic              Error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              req_err;
    logic              enter_resp;
    logic              cur_rd;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;

    // Any one of misalignment, out-of-range index or a conflicting request type fails the access.
    assign req_err = (Adr[1:0] != 2'b00)
                   | ({2'b00, Adr[ADDR_W-1:2]} >= DEPTH_A)
                   | (MemRead & MemWrite);

    // With zero wait states the response is loaded straight from the live request.
    assign cur_rd  = (state_q == S_IDLE) ? MemRead : rd_q;
    assign cur_err = (state_q == S_IDLE) ? req_err : err_q;
    assign cur_idx = (state_q == S_IDLE) ? Adr[IDX_W+1:2] : idx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemRead | MemWrite) begin
                    idx_d   = Adr[IDX_W+1:2];
                    wdata_d = WriteData;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    err_d   = req_err;
                    cnt_d   = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            if (cur_err) begin
                rdata_d = '0;
            end else if (cur_rd) begin
                rdata_d = mem_q[cur_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // The array is never reset; a reset arriving during RESP drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP && wr_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = (state_q == S_RESP);
    assign Busy     = (state_q != S_IDLE);
    assign Error    = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed self-checking bench for mips_mem_responder
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0] adr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        mem_ready, busy, error;

    logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
    logic [15:0] adr0 = '0;
    logic [31:0] wdata0 = '0;
    logic [31:0] rdata0;
    logic        mem_ready0, busy0, error0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mips_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write), .Adr(adr),
        .WriteData(wdata), .ReadData(rdata), .MemReady(mem_ready), .Busy(busy), .Error(error)
    );

    mips_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .MemRead(mem_read0), .MemWrite(mem_write0), .Adr(adr0),
        .WriteData(wdata0), .ReadData(rdata0), .MemReady(mem_ready0), .Busy(busy0), .Error(error0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on dut and wait (bounded) for its MemReady; returns data, error and accept-to-ready latency.
    task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                       output logic [31:0] data, output logic err, output int lat, output int rdy_cyc);
        bit seen = 0;
        mem_read = rd; mem_write = wr; adr = a; wdata = wd;
        lat = -1; data = 'x; err = 1'bx; rdy_cyc = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                seen = 1; lat = k; data = rdata; err = error; rdy_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (!seen) chk("txn_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] d;
    logic        e;
    int          lat, c1, c2;
    bit          pulsed;

    initial begin
        dut.mem_q[5]   = 32'hDEADBEEF;
        dut.mem_q[12]  = 32'h11112222;
        dut.mem_q[1]   = 32'hCAFEF00D;
        dut0.mem_q[3]  = 32'h13579BDF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Read of word 5 with cycle-by-cycle Busy/MemReady profile
        mem_read = 1'b1; adr = 16'h0014;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", k), {31'd0, busy}, (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("t1_ready_c%0d", k), {31'd0, mem_ready}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
                chk("t1_rdata", rdata, 32'hDEADBEEF);
                chk("t1_error", {31'd0, error}, 32'd0);
            end else begin
                chk($sformatf("t1_error_c%0d", k), {31'd0, error}, 32'd0);
            end
            @(posedge clk); #1;
            if (k == 3) mem_read = 1'b0;
        end

        // Back-to-back write then read of 0x0020
        txn(1'b0, 1'b1, 16'h0020, 32'h12345678, d, e, lat, c1);
        chk("t2_wr_lat", lat, 3);
        chk("t2_wr_err", {31'd0, e}, 32'd0);
        txn(1'b1, 1'b0, 16'h0020, 32'h0, d, e, lat, c2);
        chk("t2_rd_data", d, 32'h12345678);
        chk("t2_rd_err", {31'd0, e}, 32'd0);
        chk("t2_interval", c2 - c1, 4);

        // Reset in the first WAIT cycle of a write
        mem_write = 1'b1; adr = 16'h0030; wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        chk("t3_busy_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1; mem_write = 1'b0;
        #1;
        chk("t3_busy_rst", {31'd0, busy}, 32'd0);
        chk("t3_rdata_rst", rdata, 32'd0);
        pulsed = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_ready) pulsed = 1;
            if (k == 1) rst = 1'b0;
        end
        chk("t3_no_ready", {31'd0, pulsed}, 32'd0);
        chk("t3_error", {31'd0, error}, 32'd0);
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 16'h0030, 32'h0, d, e, lat, c1);
        chk("t3_old_data", d, 32'h11112222);

        // Misaligned and out-of-range accesses
        txn(1'b1, 1'b0, 16'h0022, 32'h0, d, e, lat, c1);
        chk("t4_mis_err", {31'd0, e}, 32'd1);
        chk("t4_mis_data", d, 32'd0);
        chk("t4_mis_lat", lat, 3);
        txn(1'b0, 1'b1, 16'h0022, 32'hFFFFFFFF, d, e, lat, c1);
        chk("t4_miswr_err", {31'd0, e}, 32'd1);
        txn(1'b1, 1'b0, 16'h0020, 32'h0, d, e, lat, c1);
        chk("t4_word8_kept", d, 32'h12345678);
        txn(1'b1, 1'b0, 16'h1000, 32'h0, d, e, lat, c1);
        chk("t4_range_err", {31'd0, e}, 32'd1);
        chk("t4_range_data", d, 32'd0);
        txn(1'b1, 1'b0, 16'h0FFC, 32'h0, d, e, lat, c1);
        chk("t4_last_ok", {31'd0, e}, 32'd0);

        // Read and write asserted together
        txn(1'b1, 1'b1, 16'h0004, 32'h0BADBEEF, d, e, lat, c1);
        chk("t5_both_err", {31'd0, e}, 32'd1);
        chk("t5_both_data", d, 32'd0);
        txn(1'b1, 1'b0, 16'h0004, 32'h0, d, e, lat, c1);
        chk("t5_word1_kept", d, 32'hCAFEF00D);
        chk("t5_err_idle", {31'd0, error}, 32'd0);

        // Zero wait states
        mem_read0 = 1'b1; adr0 = 16'h000C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t6_busy_c%0d", k), {31'd0, busy0}, (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t6_ready_c%0d", k), {31'd0, mem_ready0}, (k == 1) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk("t6_rdata", rdata0, 32'h13579BDF);
                chk("t6_error", {31'd0, error0}, 32'd0);
            end
            @(posedge clk); #1;
            if (k == 1) mem_read0 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
